// File: rtl/pkt_tx_sched_if.sv
// pkt_tx_sched_if: request/grant bundle between channel flags, scheduler and TX packet reader
interface pkt_tx_sched_if #(
    parameter int CHAN_NUMS = 8,
    parameter int IDX_W     = 3,
    parameter int WT_W      = 4
);
    logic [CHAN_NUMS-1:0]      req;
    logic [CHAN_NUMS-1:0]      chan_en;
    logic [CHAN_NUMS*WT_W-1:0] wt_cfg;
    logic                      ack;
    logic [CHAN_NUMS-1:0]      grant;
    logic [IDX_W-1:0]          grant_idx;
    logic                      grant_vld;
    logic                      busy;
    modport master (input req, chan_en, wt_cfg, ack, output grant, grant_idx, grant_vld, busy);
    modport slave (output req, chan_en, wt_cfg, ack, input grant, grant_idx, grant_vld, busy);
endinterface

// File: rtl/pkt_tx_sched.sv
// pkt_tx_sched: weighted round-robin grant of the TX packet path; weights enabled by PKT_TX_SCHED_WEIGHT_EN
module pkt_tx_sched #(
    parameter int CHAN_NUMS = 8,
    parameter int IDX_W     = 3,
    parameter int WT_W      = 4
) (
    input logic            clk,
    input logic            rst,
    pkt_tx_sched_if.master bus
);
    typedef enum logic [2:0] {ST_IDLE = 3'b001, ST_GRANT = 3'b010, ST_GAP = 3'b100} state_t;
    state_t               state;
    logic [IDX_W-1:0]     ptr;
    logic [IDX_W-1:0]     win;
    logic [IDX_W-1:0]     nxt;
    logic [CHAN_NUMS-1:0] ereq;
    // first enabled request at or above ptr, wrapping past the top channel
    always_comb begin
        ereq = bus.req & bus.chan_en;
        nxt = bus.grant_idx + 1'b1;
        win = ptr;
        for (int k = CHAN_NUMS - 1; k >= 0; k--) begin
            if (ereq[ptr + IDX_W'(k)]) win = ptr + IDX_W'(k);
        end
    end
`ifdef PKT_TX_SCHED_WEIGHT_EN
    logic [WT_W-1:0]  srv_cnt;
    logic [WT_W-1:0]  wt_raw;
    logic [WT_W-1:0]  wt;
    logic [WT_W-1:0]  cnt_inc;
    logic [IDX_W-1:0] last_c;
    logic             stay;
    // weight of the granted channel and whether it keeps the pointer for another packet
    always_comb begin
        wt_raw = bus.wt_cfg[bus.grant_idx*WT_W +: WT_W];
        wt = (wt_raw == '0) ? WT_W'(1) : wt_raw;
        cnt_inc = (&srv_cnt) ? srv_cnt : srv_cnt + 1'b1;
        stay = ({1'b0, srv_cnt} + (WT_W + 1)'(1)) < {1'b0, wt};
    end
`endif
    // grant state machine with registered outputs and pointer/credit bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            bus.grant     <= '0;
            bus.grant_idx <= '0;
            bus.grant_vld <= 1'b0;
            bus.busy      <= 1'b0;
            ptr           <= '0;
`ifdef PKT_TX_SCHED_WEIGHT_EN
            srv_cnt       <= '0;
            last_c        <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: if (ereq != '0) begin
                    state         <= ST_GRANT;
                    bus.grant     <= CHAN_NUMS'(1) << win;
                    bus.grant_idx <= win;
                    bus.grant_vld <= 1'b1;
                    bus.busy      <= 1'b1;
`ifdef PKT_TX_SCHED_WEIGHT_EN
                    if (win != last_c) srv_cnt <= '0;
`endif
                end
                ST_GRANT: if (bus.ack || !bus.req[bus.grant_idx]) begin
                    state         <= ST_GAP;
                    bus.grant     <= '0;
                    bus.grant_vld <= 1'b0;
                    if (bus.ack) begin
`ifdef PKT_TX_SCHED_WEIGHT_EN
                        ptr     <= stay ? bus.grant_idx : nxt;
                        srv_cnt <= stay ? cnt_inc : '0;
                        last_c  <= bus.grant_idx;
`else
                        ptr     <= nxt;
`endif
                    end
                end
                ST_GAP: begin
                    state    <= ST_IDLE;
                    bus.busy <= 1'b0;
                end
                default: begin
                    state         <= ST_IDLE;
                    bus.grant     <= '0;
                    bus.grant_vld <= 1'b0;
                    bus.busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pkt_tx_sched.sv
// tb_pkt_tx_sched: randomized and directed checks of pkt_tx_sched against a behavioural scheduler model
module tb_pkt_tx_sched;
    localparam int N = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pkt_tx_sched_if #(.CHAN_NUMS(8), .IDX_W(3), .WT_W(4)) bus ();
    pkt_tx_sched #(.CHAN_NUMS(8), .IDX_W(3), .WT_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_chk = 0;
    int n_fail = 0;
    bit cmp_on = 1'b0;
    int seq[$];

    int m_gi;
    bit m_gap;
    int m_ptr;
    int m_cnt;
    int m_last;
    logic [7:0] m_e;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int weight(input int c);
        int w = int'((bus.wt_cfg >> (4 * c)) & 32'hF);
        return (w == 0) ? 1 : w;
    endfunction

    // model: which channel holds the grant (-1 none), whether the settle gap is in progress, pointer and credit
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_gi = -1; m_gap = 1'b0; m_ptr = 0; m_cnt = 0; m_last = 0;
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else if (m_gi < 0) begin
            m_e = bus.req & bus.chan_en;
            for (int k = 0; k < N; k++) if (m_gi < 0 && m_e[(m_ptr + k) % N]) m_gi = (m_ptr + k) % N;
            if (m_gi >= 0 && m_gi != m_last) m_cnt = 0;
        end else if (bus.ack || !bus.req[m_gi]) begin
            if (bus.ack) begin
`ifdef PKT_TX_SCHED_WEIGHT_EN
                if (m_cnt + 1 < weight(m_gi)) begin
                    m_ptr = m_gi;
                    m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
                end else begin
                    m_ptr = (m_gi + 1) % N;
                    m_cnt = 0;
                end
                m_last = m_gi;
`else
                m_ptr = (m_gi + 1) % N;
`endif
            end
            m_gi = -1;
            m_gap = 1'b1;
        end
    end

    // every cycle outside reset the DUT outputs must match the model
    always @(negedge clk) begin
        if (cmp_on && !rst) begin
            chk("grant_vld", int'(bus.grant_vld), int'(m_gi >= 0));
            chk("grant", int'(bus.grant), (m_gi >= 0) ? (1 << m_gi) : 0);
            chk("busy", int'(bus.busy), int'((m_gi >= 0) || m_gap));
            if (m_gi >= 0) chk("grant_idx", int'(bus.grant_idx), m_gi);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.ack = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_vld(input string name);
        int t = 0;
        while (!bus.grant_vld && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!bus.grant_vld) chk({name, "_timeout"}, 0, 1);
    endtask

    // take n grants, acking each one cycle after it is seen, recording the granted channels
    task automatic serve(input int n, input bit gap_chk);
        int t;
        for (int j = 0; j < n; j++) begin
            t = 0;
            while (!bus.grant_vld && t < 20) begin
                @(negedge clk);
                t++;
            end
            if (!bus.grant_vld) begin
                chk("serve_timeout", 0, 1);
                j = n;
            end else begin
                seq.push_back(int'(bus.grant_idx));
                if (gap_chk && j > 0) chk("ack_to_grant", t + 1, 3);
                @(negedge clk);
                bus.ack = 1'b1;
                @(negedge clk);
                bus.ack = 1'b0;
            end
        end
    endtask

    // expected order packed one channel per nibble, first grant in the lowest nibble
    task automatic chk_seq(input string name, input int n, input logic [63:0] e);
        chk({name, "_len"}, seq.size(), n);
        for (int i = 0; i < n; i++) chk(name, (i < seq.size()) ? seq[i] : -1, int'((e >> (4 * i)) & 64'hF));
    endtask

    initial begin
        bus.req = '0; bus.chan_en = 8'hFF; bus.wt_cfg = '0; bus.ack = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cmp_on = 1'b1;
        @(negedge clk);
        chk("idle_grant", int'(bus.grant), 0);
        chk("idle_vld", int'(bus.grant_vld), 0);
        chk("idle_busy", int'(bus.busy), 0);
        bus.req = 8'h10;
        @(negedge clk);
        chk("first_grant", int'(bus.grant), 8'h10);
        chk("first_idx", int'(bus.grant_idx), 4);

        do_reset();
        bus.req = 8'hFF;
        bus.wt_cfg = 32'h1111_1111;
        seq.delete();
        serve(9, 1'b1);
        chk_seq("rr_order", 9, 64'h0_7654_3210);

        do_reset();
        bus.req = 8'h03;
        bus.wt_cfg = 32'h0000_0013;
        seq.delete();
`ifdef PKT_TX_SCHED_WEIGHT_EN
        serve(8, 1'b0);
        chk_seq("wrr_order", 8, 64'h1000_1000);
`else
        serve(4, 1'b0);
        chk_seq("rr2_order", 4, 64'h1010);
`endif

        do_reset();
        bus.req = 8'h04;
        wait_vld("revoke_grant");
        chk("revoke_idx", int'(bus.grant_idx), 2);
        bus.req = 8'h00;
        @(negedge clk);
        chk("revoked_vld", int'(bus.grant_vld), 0);
        chk("revoked_busy", int'(bus.busy), 1);
        bus.req = 8'h09;
        wait_vld("after_revoke");
        chk("ptr_kept_idx", int'(bus.grant_idx), 0);

        do_reset();
        bus.req = 8'h10;
        wait_vld("pre_reset");
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_grant", int'(bus.grant), 0);
        chk("rst_vld", int'(bus.grant_vld), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_idx", int'(bus.grant_idx), 0);
        bus.req = 8'h80;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("wrap_grant", int'(bus.grant), 8'h80);
        chk("wrap_idx", int'(bus.grant_idx), 7);

        do_reset();
        bus.chan_en = 8'hFE;
        bus.req = 8'h01;
        repeat (4) begin
            @(negedge clk);
            chk("disabled_vld", int'(bus.grant_vld), 0);
        end
        bus.ack = 1'b1;
        @(negedge clk);
        bus.ack = 1'b0;
        chk("idle_ack_busy", int'(bus.busy), 0);
        bus.chan_en = 8'hFF;
        @(negedge clk);
        chk("enabled_grant", int'(bus.grant), 8'h01);

        do_reset();
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (i % 256 == 0) bus.wt_cfg = $urandom;
            if ($urandom_range(0, 3) == 0) bus.req = bus.req ^ 8'($urandom & $urandom & $urandom & $urandom);
            if ($urandom_range(0, 15) == 0) bus.chan_en = 8'($urandom | $urandom);
            bus.ack = ($urandom_range(0, 2) == 0);
        end
        bus.ack = 1'b0;
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d checks %0d failures", n_chk, n_fail);
        $fatal(1, "watchdog");
    end
endmodule
